// File: rtl/vmem_arbiter_if.sv
// Video memory arbiter bus: display read port, two writer ports, memory port and miss statistics.
// The arbiter sits on the slave side; clients and the memory sit on the master side.
interface vmem_arbiter_if #(
   parameter int AW    = 19,
   parameter int DW    = 24,
   parameter int CNT_W = 16
);
   logic             disp_req;
   logic [AW-1:0]    disp_addr;
   logic [DW-1:0]    disp_data;
   logic             disp_rvalid;
   logic             disp_miss;
   logic             w0_req;
   logic [AW-1:0]    w0_addr;
   logic [DW-1:0]    w0_data;
   logic             w0_gnt;
   logic             w1_req;
   logic [AW-1:0]    w1_addr;
   logic [DW-1:0]    w1_data;
   logic             w1_gnt;
   logic [AW-1:0]    mem_addr;
   logic             mem_we;
   logic [DW-1:0]    mem_wdata;
   logic [DW-1:0]    mem_rdata;
   logic [CNT_W-1:0] miss_cnt;

   modport slave (
      input  disp_req, disp_addr, w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data, mem_rdata,
      output disp_data, disp_rvalid, disp_miss, w0_gnt, w1_gnt, mem_addr, mem_we, mem_wdata, miss_cnt
   );

   modport master (
      output disp_req, disp_addr, w0_req, w0_addr, w0_data, w1_req, w1_addr, w1_data, mem_rdata,
      input  disp_data, disp_rvalid, disp_miss, w0_gnt, w1_gnt, mem_addr, mem_we, mem_wdata, miss_cnt
   );
endinterface

// File: rtl/vmem_arbiter.sv
// Single-port video memory arbiter: display reads win, two writers share round-robin,
// and a starved writer may steal one display slot (the display then repeats the held pixel).
module vmem_arbiter #(
   parameter int AW           = 19,
   parameter int DW           = 24,
   parameter int STARVE_LIMIT = 1024,
   parameter int CNT_W        = 16
) (
   input  logic           clk,
   input  logic           rst,
   vmem_arbiter_if.slave  bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {OWN_IDLE, OWN_DISP, OWN_WRITE, OWN_STEAL} owner_t;

   owner_t           owner;
   owner_t           prev_owner;
   logic [SW-1:0]    starve_cnt;
   logic             rr_ptr;
   logic [DW-1:0]    hold;
   logic [CNT_W-1:0] miss_cnt;
   logic             pend;
   logic             wsel;
   logic             wgrant;

   // Owner selection; everything is forced idle while reset is held so no write can slip out.
   always_comb begin
      pend  = bus.w0_req | bus.w1_req;
      wsel  = (bus.w0_req & bus.w1_req) ? rr_ptr : bus.w1_req;
      owner = OWN_IDLE;
      if (!rst) begin
         if (bus.disp_req && pend && (starve_cnt >= LIMIT))
            owner = OWN_STEAL;
         else if (bus.disp_req)
            owner = OWN_DISP;
         else if (pend)
            owner = OWN_WRITE;
      end
      wgrant = (owner == OWN_WRITE) || (owner == OWN_STEAL);
   end

   always_comb begin
      bus.w0_gnt    = wgrant & ~wsel;
      bus.w1_gnt    = wgrant & wsel;
      bus.mem_we    = wgrant;
      bus.mem_addr  = bus.disp_addr;
      bus.mem_wdata = wsel ? bus.w1_data : bus.w0_data;
      if (wgrant)
         bus.mem_addr = wsel ? bus.w1_addr : bus.w0_addr;
   end

   // Return path looks only at who owned the previous slot; a stolen slot replays the hold pixel.
   always_comb begin
      bus.disp_rvalid = (prev_owner == OWN_DISP) || (prev_owner == OWN_STEAL);
      bus.disp_miss   = (prev_owner == OWN_STEAL);
      bus.disp_data   = (prev_owner == OWN_DISP) ? bus.mem_rdata : hold;
   end

   assign bus.miss_cnt = miss_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_owner <= OWN_IDLE;
         rr_ptr     <= 1'b0;
         starve_cnt <= '0;
         hold       <= '0;
         miss_cnt   <= '0;
      end else begin
         prev_owner <= owner;
         if (wgrant)
            rr_ptr <= ~wsel;
         if (wgrant || !pend)
            starve_cnt <= '0;
         else if (starve_cnt < LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
         if (prev_owner == OWN_DISP)
            hold <= bus.mem_rdata;
         if ((owner == OWN_STEAL) && (miss_cnt != '1))
            miss_cnt <= miss_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: two instances (long and short starvation limit) share one stimulus stream,
// each backed by its own memory; a cycle model predicts every output and directed literals pin it.
module tb_vmem_arbiter;
   localparam int AW = 19;
   localparam int DW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic          disp_req, w0_req, w1_req;
   logic [AW-1:0] disp_addr, w0_addr, w1_addr;
   logic [DW-1:0] w0_data, w1_data;
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   vmem_arbiter_if #(.AW(AW), .DW(DW), .CNT_W(16)) bus_a ();
   vmem_arbiter_if #(.AW(AW), .DW(DW), .CNT_W(2))  bus_b ();

   assign bus_a.disp_req = disp_req;   assign bus_b.disp_req = disp_req;
   assign bus_a.disp_addr = disp_addr; assign bus_b.disp_addr = disp_addr;
   assign bus_a.w0_req = w0_req;       assign bus_b.w0_req = w0_req;
   assign bus_a.w0_addr = w0_addr;     assign bus_b.w0_addr = w0_addr;
   assign bus_a.w0_data = w0_data;     assign bus_b.w0_data = w0_data;
   assign bus_a.w1_req = w1_req;       assign bus_b.w1_req = w1_req;
   assign bus_a.w1_addr = w1_addr;     assign bus_b.w1_addr = w1_addr;
   assign bus_a.w1_data = w1_data;     assign bus_b.w1_data = w1_data;

   vmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(1024), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a));
   vmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b));

   function automatic logic [DW-1:0] initv(input logic [AW-1:0] a);
      logic [31:0] t;
      t = {13'b0, a} * 32'd7;
      return t[23:0] ^ 24'h5A5A5A;
   endfunction

   function automatic int key(input int i, input logic [AW-1:0] a);
      return (i << 20) + int'({13'b0, a});
   endfunction

   // Memories seen by the DUTs: synchronous read-before-write, preloaded with initv().
   logic [DW-1:0] envm [int];

   function automatic logic [DW-1:0] env_rd(input int i, input logic [AW-1:0] a);
      return envm.exists(key(i, a)) ? envm[key(i, a)] : initv(a);
   endfunction

   always @(posedge clk) begin
      bus_a.mem_rdata <= env_rd(0, bus_a.mem_addr);
      bus_b.mem_rdata <= env_rd(1, bus_b.mem_addr);
      if (bus_a.mem_we) envm[key(0, bus_a.mem_addr)] = bus_a.mem_wdata;
      if (bus_b.mem_we) envm[key(1, bus_b.mem_addr)] = bus_b.mem_wdata;
   end

   task automatic cmp(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d: got %h, expected %h", nm, i, act, exp);
      end
   endtask

   // Model: last slot kind (0 other, 1 display read, 2 stolen), writer turn, wait age, hold pixel.
   int            m_turn[2], m_wait[2], m_last[2], m_miss[2];
   logic [DW-1:0] m_hold[2], m_rdat[2];
   int            p_turn[2], p_wait[2], p_last[2], p_miss[2], p_key[2];
   logic [DW-1:0] p_hold[2], p_rdat[2], p_wd[2];
   bit            p_we[2];
   logic [DW-1:0] shadow [int];

   function automatic int lim(input int i);  return (i == 0) ? 1024 : 4;  endfunction
   function automatic int cmax(input int i); return (i == 0) ? 65535 : 3; endfunction

   function automatic logic [DW-1:0] sh_rd(input int i, input logic [AW-1:0] a);
      return shadow.exists(key(i, a)) ? shadow[key(i, a)] : initv(a);
   endfunction

   task automatic chk(input int i, input logic g0, input logic g1, input logic we,
                      input logic [AW-1:0] ma, input logic [DW-1:0] wd, input logic [DW-1:0] dd,
                      input logic rv, input logic ms, input logic [15:0] mc);
      bit pend, steal, grant;
      int who;
      logic [AW-1:0] wa;
      if (rst) begin
         cmp("rst_gnt", i, 32'({g0, g1}), 0);
         cmp("rst_mem_we", i, 32'(we), 0);
         cmp("rst_disp_data", i, 32'(dd), 0);
         cmp("rst_rvalid", i, 32'({rv, ms}), 0);
         cmp("rst_miss_cnt", i, 32'(mc), 0);
         return;
      end
      pend  = w0_req || w1_req;
      who   = (w0_req && w1_req) ? m_turn[i] : (w1_req ? 1 : 0);
      steal = disp_req && pend && (m_wait[i] >= lim(i));
      grant = steal || (!disp_req && pend);
      wa    = (who == 1) ? w1_addr : w0_addr;
      cmp("w0_gnt", i, 32'(g0), 32'(grant && who == 0));
      cmp("w1_gnt", i, 32'(g1), 32'(grant && who == 1));
      cmp("mem_we", i, 32'(we), 32'(grant));
      cmp("mem_addr", i, 32'(ma), 32'(grant ? wa : disp_addr));
      if (grant) cmp("mem_wdata", i, 32'(wd), 32'((who == 1) ? w1_data : w0_data));
      cmp("disp_rvalid", i, 32'(rv), 32'(m_last[i] != 0));
      cmp("disp_miss", i, 32'(ms), 32'(m_last[i] == 2));
      cmp("disp_data", i, 32'(dd), 32'((m_last[i] == 1) ? m_rdat[i] : m_hold[i]));
      cmp("miss_cnt", i, 32'(mc), 32'(m_miss[i]));
      p_turn[i] = grant ? 1 - who : m_turn[i];
      p_wait[i] = (grant || !pend) ? 0 : ((m_wait[i] < lim(i)) ? m_wait[i] + 1 : m_wait[i]);
      p_last[i] = steal ? 2 : (disp_req ? 1 : 0);
      p_hold[i] = (m_last[i] == 1) ? m_rdat[i] : m_hold[i];
      p_miss[i] = (steal && m_miss[i] < cmax(i)) ? m_miss[i] + 1 : m_miss[i];
      p_rdat[i] = sh_rd(i, disp_addr);
      p_we[i]   = grant;
      p_key[i]  = key(i, wa);
      p_wd[i]   = (who == 1) ? w1_data : w0_data;
   endtask

   task automatic advance(input int i);
      if (rst) begin
         m_turn[i] = 0; m_wait[i] = 0; m_last[i] = 0; m_miss[i] = 0;
         m_hold[i] = '0; m_rdat[i] = '0;
      end else begin
         m_turn[i] = p_turn[i]; m_wait[i] = p_wait[i]; m_last[i] = p_last[i];
         m_miss[i] = p_miss[i]; m_hold[i] = p_hold[i]; m_rdat[i] = p_rdat[i];
         if (p_we[i]) shadow[p_key[i]] = p_wd[i];
      end
   endtask

   always @(posedge clk) begin
      advance(0);
      advance(1);
   end

   always @(negedge clk) begin
      chk(0, bus_a.w0_gnt, bus_a.w1_gnt, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata,
          bus_a.disp_data, bus_a.disp_rvalid, bus_a.disp_miss, bus_a.miss_cnt);
      chk(1, bus_b.w0_gnt, bus_b.w1_gnt, bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata,
          bus_b.disp_data, bus_b.disp_rvalid, bus_b.disp_miss, 16'(bus_b.miss_cnt));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; disp_req = 0; disp_addr = '0;
      w0_req = 0; w0_addr = '0; w0_data = '0;
      w1_req = 0; w1_addr = '0; w1_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // display priority over a pending writer
      disp_req = 1; disp_addr = 19'h12345;
      w0_req = 1; w0_addr = 19'h00200; w0_data = 24'hABCDEF;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         cmp("prio_mem_we", 0, 32'(bus_a.mem_we), 0);
         cmp("prio_w0_gnt", 0, 32'(bus_a.w0_gnt), 0);
         if (k >= 1) begin
            cmp("prio_rvalid", 0, 32'(bus_a.disp_rvalid), 1);
            cmp("prio_data", 0, 32'(bus_a.disp_data), 32'h5DACB9);
         end
         tick();
      end

      // async reset in the middle of a write cycle
      disp_req = 0;
      @(negedge clk);
      cmp("pre_rst_w0_gnt", 0, 32'(bus_a.w0_gnt), 1);
      #2 rst = 1'b1; disp_req = 1;
      #1;
      cmp("rst_async_we", 0, 32'(bus_a.mem_we), 0);
      cmp("rst_async_gnt", 0, 32'({bus_a.w0_gnt, bus_a.w1_gnt}), 0);
      cmp("rst_async_miss_cnt", 1, 32'(bus_b.miss_cnt), 0);
      cmp("rst_async_data", 1, 32'(bus_b.disp_data), 0);
      cmp("rst_async_we", 1, 32'(bus_b.mem_we), 0);
      tick();
      tick();
      rst = 1'b0; w0_req = 0;
      @(negedge clk);
      cmp("post_rst_rvalid", 0, 32'(bus_a.disp_rvalid), 0);
      cmp("post_rst_rvalid", 1, 32'(bus_b.disp_rvalid), 0);
      tick();

      // round-robin between two held writers during blanking
      disp_req = 0;
      w0_req = 1; w0_addr = 19'h00300; w0_data = 24'h111111;
      w1_req = 1; w1_addr = 19'h00301; w1_data = 24'h222222;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         cmp("rr_w0_gnt", 0, 32'(bus_a.w0_gnt), 32'(k % 2 == 0));
         cmp("rr_w1_gnt", 0, 32'(bus_a.w1_gnt), 32'(k % 2 == 1));
         tick();
      end
      w1_req = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cmp("solo_w0_gnt", 0, 32'(bus_a.w0_gnt), 1);
         cmp("solo_w0_gnt", 1, 32'(bus_b.w0_gnt), 1);
         tick();
      end

      // starvation steal on the short-limit instance
      w0_req = 0; disp_req = 1; disp_addr = 19'h00777;
      w1_req = 1; w1_addr = 19'h00010; w1_data = 24'hFF00FF;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         if (k < 4) cmp("starve_no_gnt", 1, 32'(bus_b.w1_gnt), 0);
         if (k == 4) begin
            cmp("starve_gnt", 1, 32'(bus_b.w1_gnt), 1);
            cmp("starve_addr", 1, 32'(bus_b.mem_addr), 32'h10);
         end
         if (k == 5) begin
            cmp("steal_miss", 1, 32'(bus_b.disp_miss), 1);
            cmp("steal_data", 1, 32'(bus_b.disp_data), 32'h5A6E1B);
            cmp("steal_miss_cnt", 1, 32'(bus_b.miss_cnt), 1);
         end
         if (k == 6) cmp("steal_miss_clr", 1, 32'(bus_b.disp_miss), 0);
         tick();
         if (k == 4) w1_req = 0;
      end
      disp_addr = 19'h00010;
      tick();
      @(negedge clk);
      cmp("steal_readback", 1, 32'(bus_b.disp_data), 32'hFF00FF);
      cmp("nosteal_readback", 0, 32'(bus_a.disp_data), 32'h5A5A2A);
      tick();

      // miss counter saturation with five steals
      disp_addr = 19'h00777; w1_req = 1;
      repeat (26) tick();
      @(negedge clk);
      cmp("sat_miss_cnt", 1, 32'(bus_b.miss_cnt), 3);
      cmp("sat_miss_cnt", 0, 32'(bus_a.miss_cnt), 0);
      tick();

      // blanking burst of eight W0 writes
      disp_req = 0; w1_req = 0; w0_req = 1;
      for (int k = 0; k < 8; k++) begin
         w0_addr = 19'h00400 + 19'(k);
         w0_data = 24'h0A0000 + 24'(k);
         @(negedge clk);
         cmp("burst_gnt", 0, 32'(bus_a.w0_gnt), 1);
         cmp("burst_gnt", 1, 32'(bus_b.w0_gnt), 1);
         cmp("burst_miss", 1, 32'(bus_b.disp_miss), 0);
         cmp("burst_miss_cnt", 1, 32'(bus_b.miss_cnt), 3);
         tick();
      end
      w0_req = 0; disp_req = 1; disp_addr = 19'h00403;
      tick();
      @(negedge clk);
      cmp("burst_readback", 0, 32'(bus_a.disp_data), 32'h0A0003);
      cmp("burst_readback", 1, 32'(bus_b.disp_data), 32'h0A0003);
      tick();
      disp_req = 0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
